// File: rtl/array_14_ctrl.sv
// Init sequencer and round-robin arbiter for the single-port 4x34 masked array.
// Zeroes the array after reset, then shares RW0 between requesters A and B.
module array_14_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int DW    = 34,
    parameter int MW    = 2
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic          a_wmode,
    input  logic [AW-1:0] a_addr,
    input  logic [MW-1:0] a_wmask,
    input  logic [DW-1:0] a_wdata,
    output logic          a_rsp_valid,
    output logic [DW-1:0] a_rsp_data,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic          b_wmode,
    input  logic [AW-1:0] b_addr,
    input  logic [MW-1:0] b_wmask,
    input  logic [DW-1:0] b_wdata,
    output logic          b_rsp_valid,
    output logic [DW-1:0] b_rsp_data,
    output logic          init_done,
    output logic          RW0_en,
    output logic          RW0_wmode,
    output logic [AW-1:0] RW0_addr,
    output logic [MW-1:0] RW0_wmask,
    output logic [DW-1:0] RW0_wdata,
    input  logic [DW-1:0] RW0_rdata
);
    localparam logic [1:0] S_WAIT = 2'd0;
    localparam logic [1:0] S_INIT = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] init_cnt_q, init_cnt_d;
    logic          rr_q, rr_d;      // 0: A has priority, 1: B
    logic          pend_q, own_q;   // read response due next cycle, and to whom (1=B)
    logic [DW-1:0] a_hold_q, b_hold_q;
    logic          run, a_fire, b_fire;

    assign run       = (state_q == S_RUN);
    assign init_done = run;
    assign a_ready   = run && a_valid && (!b_valid || !rr_q);
    assign b_ready   = run && b_valid && (!a_valid ||  rr_q);
    assign a_fire    = a_valid && a_ready;
    assign b_fire    = b_valid && b_ready;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        rr_d       = rr_q;
        case (state_q)
            S_WAIT: state_d = S_INIT;
            S_INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == AW'(DEPTH - 1)) state_d = S_RUN;
            end
            default: begin
                if (a_fire) rr_d = 1'b1;
                if (b_fire) rr_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        RW0_en    = 1'b0;
        RW0_wmode = 1'b0;
        RW0_addr  = '0;
        RW0_wmask = '0;
        RW0_wdata = '0;
        if (state_q == S_INIT) begin
            RW0_en    = 1'b1;
            RW0_wmode = 1'b1;
            RW0_addr  = init_cnt_q;
            RW0_wmask = '1;
        end else if (a_fire) begin
            RW0_en    = 1'b1;
            RW0_wmode = a_wmode;
            RW0_addr  = a_addr;
            RW0_wmask = a_wmask;
            RW0_wdata = a_wdata;
        end else if (b_fire) begin
            RW0_en    = 1'b1;
            RW0_wmode = b_wmode;
            RW0_addr  = b_addr;
            RW0_wmask = b_wmask;
            RW0_wdata = b_wdata;
        end
    end

    // Array read data arrives the cycle after the read, so rsp_data passes it straight through.
    assign a_rsp_valid = pend_q && !own_q;
    assign b_rsp_valid = pend_q &&  own_q;
    assign a_rsp_data  = a_rsp_valid ? RW0_rdata : a_hold_q;
    assign b_rsp_data  = b_rsp_valid ? RW0_rdata : b_hold_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_WAIT;
            init_cnt_q <= '0;
            rr_q       <= 1'b0;
            pend_q     <= 1'b0;
            own_q      <= 1'b0;
            a_hold_q   <= '0;
            b_hold_q   <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            rr_q       <= rr_d;
            pend_q     <= (a_fire && !a_wmode) || (b_fire && !b_wmode);
            own_q      <= b_fire;
            if (a_rsp_valid) a_hold_q <= RW0_rdata;
            if (b_rsp_valid) b_hold_q <= RW0_rdata;
        end
    end
endmodule

// File: tb/tb_array_14_ctrl.sv
// Randomised bench for array_14_ctrl with a behavioural array and a reference model
// of init sequencing, round-robin grants, memory contents and response routing.
module tb_array_14_ctrl;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        a_valid = 1'b0, a_wmode = 1'b0, b_valid = 1'b0, b_wmode = 1'b0;
    logic [1:0]  a_addr = '0, a_wmask = '0, b_addr = '0, b_wmask = '0;
    logic [33:0] a_wdata = '0, b_wdata = '0;
    logic        a_ready, b_ready, a_rsp_valid, b_rsp_valid, init_done;
    logic [33:0] a_rsp_data, b_rsp_data;
    logic        RW0_en, RW0_wmode;
    logic [1:0]  RW0_addr, RW0_wmask;
    logic [33:0] RW0_wdata, RW0_rdata;

    int total = 0;
    int bad   = 0;

    array_14_ctrl dut (
        .clock(clock), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_wmode(a_wmode), .a_addr(a_addr),
        .a_wmask(a_wmask), .a_wdata(a_wdata), .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_wmode(b_wmode), .b_addr(b_addr),
        .b_wmask(b_wmask), .b_wdata(b_wdata), .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
        .init_done(init_done), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode), .RW0_addr(RW0_addr),
        .RW0_wmask(RW0_wmask), .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata)
    );

    always #5 clock = ~clock;

    // Behavioural array: no reset, masked write at the edge, registered read data.
    logic [33:0] arr [4];
    initial begin
        RW0_rdata = '0;
        for (int i = 0; i < 4; i++) arr[i] = {$urandom, $urandom};
    end
    always @(posedge clock) begin
        if (RW0_en) begin
            if (RW0_wmode) begin
                for (int g = 0; g < 2; g++)
                    if (RW0_wmask[g]) arr[RW0_addr][g*17 +: 17] <= RW0_wdata[g*17 +: 17];
            end else begin
                RW0_rdata <= arr[RW0_addr];
            end
        end
    end

    // Reference model state
    logic [33:0] m_mem [4];
    bit          m_rr;          // side favoured on a tie: 0=A, 1=B
    bit          m_pa, m_pb;    // response expected this cycle
    logic [33:0] m_da, m_db, m_la, m_lb;
    int          m_cyc;         // cycles since reset release

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [33:0] apply_mask(logic [33:0] old, logic [1:0] m, logic [33:0] d);
        logic [33:0] r;
        r = old;
        if (m[0]) r[16:0]  = d[16:0];
        if (m[1]) r[33:17] = d[33:17];
        return r;
    endfunction

    task automatic model_reset();
        m_rr = 0; m_pa = 0; m_pb = 0;
        m_da = '0; m_db = '0; m_la = '0; m_lb = '0;
        m_cyc = 0;
    endtask

    // One cycle: check at negedge, advance model, then step past the posedge.
    // With rst_now, reset is asserted right after the checks so nothing fires at that edge.
    task automatic tick(input bit rst_now, output bit af, output bit bf);
        bit aw, bw, in_init, run;
        logic [1:0] k;
        @(negedge clock);
        in_init = (m_cyc >= 1 && m_cyc <= 4);
        run     = (m_cyc >= 5);
        aw = run && a_valid && (!b_valid || !m_rr);
        bw = run && b_valid && (!a_valid ||  m_rr);
        chk("init_done", init_done, run);
        chk("a_ready", a_ready, aw);
        chk("b_ready", b_ready, bw);
        chk("rw0_en", RW0_en, aw || bw || in_init);
        if (in_init) begin
            k = 2'(m_cyc - 1);
            chk("init_wmode", RW0_wmode, 1);
            chk("init_addr", RW0_addr, k);
            chk("init_wmask", RW0_wmask, 2'b11);
            chk("init_wdata", RW0_wdata, 0);
        end else if (aw || bw) begin
            chk("rw0_wmode", RW0_wmode, aw ? a_wmode : b_wmode);
            chk("rw0_addr", RW0_addr, aw ? a_addr : b_addr);
            if (aw ? a_wmode : b_wmode) begin
                chk("rw0_wmask", RW0_wmask, aw ? a_wmask : b_wmask);
                chk("rw0_wdata", RW0_wdata, aw ? a_wdata : b_wdata);
            end
        end
        chk("a_rsp_valid", a_rsp_valid, m_pa);
        chk("b_rsp_valid", b_rsp_valid, m_pb);
        chk("a_rsp_data", a_rsp_data, m_pa ? m_da : m_la);
        chk("b_rsp_data", b_rsp_data, m_pb ? m_db : m_lb);
        af = 0; bf = 0;
        if (rst_now) begin
            #1 reset_n = 1'b0;
            return;
        end
        if (m_pa) m_la = m_da;
        if (m_pb) m_lb = m_db;
        m_pa = 0; m_pb = 0;
        if (in_init) m_mem[2'(m_cyc - 1)] = '0;
        if (aw) begin
            if (a_wmode) m_mem[a_addr] = apply_mask(m_mem[a_addr], a_wmask, a_wdata);
            else begin m_pa = 1; m_da = m_mem[a_addr]; end
            m_rr = 1;
        end
        if (bw) begin
            if (b_wmode) m_mem[b_addr] = apply_mask(m_mem[b_addr], b_wmask, b_wdata);
            else begin m_pb = 1; m_db = m_mem[b_addr]; end
            m_rr = 0;
        end
        af = aw; bf = bw;
        m_cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        a_valid = 0; b_valid = 0;
        #1;
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_rw0_en", RW0_en, 0);
        chk("rst_rw0_bus", {RW0_wmode, RW0_addr, RW0_wmask, RW0_wdata}, 0);
        repeat (2) begin
            @(negedge clock);
            chk("rst_a_rsp_valid", a_rsp_valid, 0);
            chk("rst_b_rsp_valid", b_rsp_valid, 0);
            chk("rst_rsp_data", {a_rsp_data, b_rsp_data}, 0);
        end
        model_reset();
        @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic set_a(bit v, bit w, logic [1:0] ad, logic [1:0] m, logic [33:0] d);
        a_valid = v; a_wmode = w; a_addr = ad; a_wmask = m; a_wdata = d;
    endtask
    task automatic set_b(bit v, bit w, logic [1:0] ad, logic [1:0] m, logic [33:0] d);
        b_valid = v; b_wmode = w; b_addr = ad; b_wmask = m; b_wdata = d;
    endtask

    initial begin
        bit af, bf;
        int fire_cyc;
        logic [63:0] r;
        model_reset();
        for (int i = 0; i < 4; i++) m_mem[i] = 'x;
        @(posedge clock); #1;
        do_reset();

        // A read of addr 2 held through WAIT/INIT; first grant lands in the first RUN cycle
        set_a(1, 0, 2'd2, 2'b00, '0);
        fire_cyc = -1;
        for (int i = 0; i < 20 && fire_cyc < 0; i++) begin
            tick(0, af, bf);
            if (af) fire_cyc = i;
        end
        chk("first_grant_cyc", fire_cyc, 5);
        set_a(0, 0, 0, 0, 0);
        tick(0, af, bf);
        chk("t1_rdata", a_rsp_data, 34'h0);

        // Masked write keeps the upper granule zero
        set_a(1, 1, 2'd1, 2'b01, 34'h3_FFFF_FFFF); tick(0, af, bf);
        set_a(1, 0, 2'd1, 2'b00, '0);              tick(0, af, bf);
        set_a(0, 0, 0, 0, 0);                      tick(0, af, bf);
        chk("t2_rdata", a_rsp_data, 34'h0_0001_FFFF);

        // B goes once so A holds priority, then both contend for 6 cycles
        set_b(1, 0, 2'd0, 0, 0); tick(0, af, bf); set_b(0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            set_a(1, 0, 2'($urandom_range(0, 3)), 0, 0);
            set_b(1, 0, 2'($urandom_range(0, 3)), 0, 0);
            tick(0, af, bf);
            chk("t3_grant_a", af, (i % 2) == 0);
            chk("t3_grant_b", bf, (i % 2) == 1);
        end
        set_a(0, 0, 0, 0, 0); set_b(0, 0, 0, 0, 0);
        tick(0, af, bf);

        // Conflicting read and write of addr 0
        set_a(1, 0, 2'd0, 0, 0);
        set_b(1, 1, 2'd0, 2'b11, 34'h1_2345_6789);
        tick(0, af, bf);
        chk("t4_a_first", af, 1);
        set_a(0, 0, 0, 0, 0);
        tick(0, af, bf);
        chk("t4_b_second", bf, 1);
        chk("t4_old_data", a_rsp_data, 34'h0);
        set_b(0, 0, 0, 0, 0);
        set_a(1, 0, 2'd0, 0, 0); tick(0, af, bf);
        set_a(0, 0, 0, 0, 0);    tick(0, af, bf);
        chk("t4_new_data", a_rsp_data, 34'h1_2345_6789);

        // Random traffic; requesters hold each request until it fires
        for (int i = 0; i < 400; i++) begin
            if (!a_valid && $urandom_range(0, 2) != 0) begin
                r = {$urandom, $urandom};
                set_a(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), r[33:0]);
            end
            if (!b_valid && $urandom_range(0, 2) != 0) begin
                r = {$urandom, $urandom};
                set_b(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), r[33:0]);
            end
            tick(0, af, bf);
            if (af) a_valid = 0;
            if (bf) b_valid = 0;
        end
        set_a(0, 0, 0, 0, 0); set_b(0, 0, 0, 0, 0);
        tick(0, af, bf);

        // Reset lands on a read fire: no response, array re-zeroed
        set_a(1, 1, 2'd3, 2'b11, 34'h2_AAAA_5555); tick(0, af, bf);
        set_a(1, 0, 2'd3, 0, 0);
        tick(1, af, bf);
        do_reset();
        set_a(0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) tick(0, af, bf);
        set_a(1, 0, 2'd3, 0, 0); tick(0, af, bf);
        set_a(0, 0, 0, 0, 0);    tick(0, af, bf);
        chk("t6_rezeroed", a_rsp_data, 34'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
